seg7_scan_driver: RTL and testbench

- Parametrised successor to the single-digit segment decoders: drives NUM_DIGITS multiplexed 7-segment digits plus dot from one shared segment bus.
- Time-multiplexes the digits with a refresh counter.
- Decodes full BCD per digit. Double-buffers the display data so a new value appears atomically at a frame boundary.
- Sits between the counter/clock datapath and the board display pins.

---
 rtl/seg7_pkg.sv | 49 ++++
 rtl/seg7_bcd_decoder.sv | 20 ++
 rtl/seg7_scan_driver.sv | 171 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment constants: segment bit positions, high-true glyphs
// for 0-9 and dash, and a BCD-to-glyph helper.
package seg7_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Glyphs are high-true, bit 0 = a ... bit 6 = g.
   localparam logic [6:0] GLYPH_0    = 7'h3F;
   localparam logic [6:0] GLYPH_1    = 7'h06;
   localparam logic [6:0] GLYPH_2    = 7'h5B;
   localparam logic [6:0] GLYPH_3    = 7'h4F;
   localparam logic [6:0] GLYPH_4    = 7'h66;
   localparam logic [6:0] GLYPH_5    = 7'h6D;
   localparam logic [6:0] GLYPH_6    = 7'h7D;
   localparam logic [6:0] GLYPH_7    = 7'h07;
   localparam logic [6:0] GLYPH_8    = 7'h7F;
   localparam logic [6:0] GLYPH_9    = 7'h6F;
   localparam logic [6:0] GLYPH_DASH = 7'h40;

   // All eight segments dark, high-true (dot included).
   localparam logic [7:0] SEG_ALL_OFF = 8'h00;

   // Non-decimal codes 10-15 render as a dash so bad data is visible.
   function automatic logic [6:0] bcd_glyph(input logic [3:0] value);
      logic [6:0] glyph;
      case (value)
         4'd0:    glyph = GLYPH_0;
         4'd1:    glyph = GLYPH_1;
         4'd2:    glyph = GLYPH_2;
         4'd3:    glyph = GLYPH_3;
         4'd4:    glyph = GLYPH_4;
         4'd5:    glyph = GLYPH_5;
         4'd6:    glyph = GLYPH_6;
         4'd7:    glyph = GLYPH_7;
         4'd8:    glyph = GLYPH_8;
         4'd9:    glyph = GLYPH_9;
         default: glyph = GLYPH_DASH;
      endcase
      return glyph;
   endfunction

endpackage

// File: rtl/seg7_bcd_decoder.sv
// Combinational BCD + dot + blank to eight high-true segments.
module seg7_bcd_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       dot,
   input  logic       blank,
   output logic [7:0] segments
);

   // Blank wins over everything, including the decimal point.
   always_comb begin
      segments = SEG_ALL_OFF;
      if (!blank) begin
         segments[SEG_G:SEG_A] = bcd_glyph(bcd);
         segments[SEG_DP]      = dot;
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed NUM_DIGITS x 7-segment scan driver with double-buffered
// display data that swaps atomically at frame boundaries.
// Optional blink support is compiled in with `define SEG7_BLINK_EN.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int ACTIVE_LOW = 1
`ifdef SEG7_BLINK_EN
   ,
   parameter int BLINK_DIV  = 25000000
`endif
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [4*NUM_DIGITS-1:0]   digits,
   input  logic [NUM_DIGITS-1:0]     dots,
   input  logic [NUM_DIGITS-1:0]     blank,
   input  logic                      load,
   output logic [7:0]                segments,
   output logic [NUM_DIGITS-1:0]     digit_sel,
   output logic                      frame_done
`ifdef SEG7_BLINK_EN
   ,
   input  logic [NUM_DIGITS-1:0]     blink
`endif
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]      IDX_MAX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic             digit_wrap;
   logic             frame_wrap;

   // Shadow (written by load) and active (displayed) buffers.
   logic [NUM_DIGITS-1:0][3:0] sh_digits, act_digits;
   logic [NUM_DIGITS-1:0]      sh_dots,   act_dots;
   logic [NUM_DIGITS-1:0]      sh_blank,  act_blank;
   logic                       pending;

   logic [3:0]                 cur_bcd;
   logic                       cur_dot;
   logic                       cur_blank;
   logic [7:0]                 dec_seg;
   logic [7:0]                 seg_q;
   logic [NUM_DIGITS-1:0]      sel_q;

   assign digit_wrap = (cnt == CNT_MAX);
   assign frame_wrap = digit_wrap && (idx == IDX_MAX);

   // Refresh counter, digit index and the frame boundary pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         idx        <= '0;
         frame_done <= 1'b0;
      end else begin
         cnt        <= digit_wrap ? '0 : cnt + 1'b1;
         frame_done <= frame_wrap;
         if (digit_wrap)
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end
   end

   // Shadow capture; a load on the swap edge keeps pending set so the
   // fresh value waits for the following frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_digits <= '0;
         sh_dots   <= '0;
         sh_blank  <= '1;
         pending   <= 1'b0;
      end else if (load) begin
         sh_digits <= digits;
         sh_dots   <= dots;
         sh_blank  <= blank;
         pending   <= 1'b1;
      end else if (frame_wrap) begin
         pending   <= 1'b0;
      end
   end

   // Active buffer only changes on the edge that returns the scan to digit 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         act_digits <= '0;
         act_dots   <= '0;
         act_blank  <= '1;
      end else if (frame_wrap && pending) begin
         act_digits <= sh_digits;
         act_dots   <= sh_dots;
         act_blank  <= sh_blank;
      end
   end

`ifdef SEG7_BLINK_EN
   localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

   logic [NUM_DIGITS-1:0] sh_blink, act_blink;
   logic [BLK_W-1:0]      blink_cnt;
   logic                  blink_phase;
   logic                  frame_phase;

   // Free-running blink timebase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLK_MAX) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + 1'b1;
      end
   end

   // Blink mask and phase follow the same buffering as blank, so a
   // digit never flips mid-frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_blink    <= '0;
         act_blink   <= '0;
         frame_phase <= 1'b0;
      end else begin
         if (load)
            sh_blink <= blink;
         if (frame_wrap && pending)
            act_blink <= sh_blink;
         if (frame_wrap)
            frame_phase <= blink_phase;
      end
   end

   assign cur_blank = act_blank[idx] | (frame_phase & act_blink[idx]);
`else
   assign cur_blank = act_blank[idx];
`endif

   assign cur_bcd = act_digits[idx];
   assign cur_dot = act_dots[idx];

   seg7_bcd_decoder u_dec (
      .bcd      (cur_bcd),
      .dot      (cur_dot),
      .blank    (cur_blank),
      .segments (dec_seg)
   );

   // Segments and select register together so they always move as a pair.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_q <= SEG_ALL_OFF;
         sel_q <= '0;
      end else begin
         seg_q <= dec_seg;
         sel_q <= SEL_ONE << idx;
      end
   end

   // Board polarity is applied only at the pins.
   assign segments  = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
   assign digit_sel = (ACTIVE_LOW != 0) ? ~sel_q : sel_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 4 cycles per digit,
// active-low outputs). Stimulus pushes expected frames; a monitor pops
// one entry per clock and compares.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] digits;
   logic [3:0]  dots;
   logic [3:0]  blank;
   logic        load;
   logic [7:0]  segments;
   logic [3:0]  digit_sel;
   logic        frame_done;
`ifdef SEG7_BLINK_EN
   logic [3:0]  blink = 4'b0000;
`endif

   typedef struct {
      logic [7:0] seg;
      logic [3:0] sel;
      logic       fd;
   } exp_t;

   exp_t exp_q[$];
   int   total  = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .NUM_DIGITS (4),
      .SCAN_DIV   (4),
      .ACTIVE_LOW (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .digits     (digits),
      .dots       (dots),
      .blank      (blank),
      .load       (load),
      .segments   (segments),
      .digit_sel  (digit_sel),
      .frame_done (frame_done)
`ifdef SEG7_BLINK_EN
      ,
      .blink      (blink)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // One expected entry per cycle: digit d held 4 cycles, frame_done on the last.
   task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
      logic [3:0] one;
      exp_t e;
      one = 4'b0001;
      for (int j = 0; j < 16; j++) begin
         case (j / 4)
            0:       e.seg = s0;
            1:       e.seg = s1;
            2:       e.seg = s2;
            default: e.seg = s3;
         endcase
         e.sel = ~(one << (j / 4));
         e.fd  = (j == 15);
         exp_q.push_back(e);
      end
   endtask

   // Wait (bounded) for frame_done sampled at negedge; check cycles taken.
   task automatic wait_fd(input string name, input int exp_n);
      int n;
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (frame_done) break;
      end
      check(name, n, exp_n);
   endtask

   // Monitor: one comparison per clock while expectations are queued.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("segments", {24'h0, segments}, {24'h0, e.seg});
         check("digit_sel", {28'h0, digit_sel}, {28'h0, e.sel});
         check("frame_done", {31'h0, frame_done}, {31'h0, e.fd});
      end
   end

   initial begin
      reset  = 1'b1;
      digits = 16'h0;
      dots   = 4'h0;
      blank  = 4'h0;
      load   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_seg", {24'h0, segments}, 32'hFF);
      check("rst_sel", {28'h0, digit_sel}, 32'hF);
      check("rst_fd", {31'h0, frame_done}, 32'h0);
      reset = 1'b0;

      // First frame after release: 16 cycles, display blank.
      wait_fd("first_fd_latency", 16);
      push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      repeat (6) @(negedge clk);
      digits = 16'h1234; dots = 4'h0; blank = 4'h0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_fd("fd_after_midload", 9);

      // 1234 shown, digit0 = 4.
      push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
      repeat (6) @(negedge clk);
      digits = 16'h5678; dots = 4'b0010; blank = 4'h0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (8) @(negedge clk);
      // Load exactly on the swap edge.
      digits = 16'h90AF; dots = 4'b0100; blank = 4'b0100; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("coincident_fd", {31'h0, frame_done}, 32'h1);
      check("pending_held", {31'h0, dut.pending}, 32'h1);
      push_frame(8'h80, 8'h78, 8'h82, 8'h92);

      // Coincident load appears one frame later: dash, dash, dark, 9.
      wait_fd("fd_frame_a", 16);
      push_frame(8'hBF, 8'hBF, 8'hFF, 8'h90);
      wait_fd("fd_frame_b", 16);
      check("pending_clear", {31'h0, dut.pending}, 32'h0);

      // Reset mid-scan: outputs off immediately.
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_seg", {24'h0, segments}, 32'hFF);
      check("midrst_sel", {28'h0, digit_sel}, 32'hF);
      check("midrst_fd", {31'h0, frame_done}, 32'h0);
      repeat (2) @(negedge clk);
      check("midrst_hold_sel", {28'h0, digit_sel}, 32'hF);
      reset = 1'b0;
      wait_fd("postrst_fd_latency", 16);
      push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      wait_fd("postrst_frame", 16);

      for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
